// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants for the branch resolve stage: branch kind codes and default PC width.
package mips_branch_pkg;

    localparam int PC_W_DEF = 16;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLT  = 3'b011;
    localparam logic [2:0] BR_BGT  = 3'b100;
    localparam logic [2:0] BR_BLE  = 3'b101;
    localparam logic [2:0] BR_BGE  = 3'b110;
    localparam logic [2:0] BR_JUMP = 3'b111;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Branch record handshake: comparator-side input record and fetch-side resolved result.
interface branch_resolve_unit_if #(parameter int PC_W = mips_branch_pkg::PC_W_DEF);

    logic            in_valid;
    logic            in_ready;
    logic [2:0]      br_kind;
    logic            lt;
    logic            gt;
    logic            eq;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] offset;
    logic            out_valid;
    logic            out_ready;
    logic            taken;
    logic [PC_W-1:0] next_pc;
    logic            flag_err;

    modport master (
        output in_valid, br_kind, lt, gt, eq, pc, offset, out_ready,
        input  in_ready, out_valid, taken, next_pc, flag_err
    );

    modport slave (
        input  in_valid, br_kind, lt, gt, eq, pc, offset, out_ready,
        output in_ready, out_valid, taken, next_pc, flag_err
    );

endinterface

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational branch condition: maps kind and comparator flags to taken / malformed-flag error.
module branch_cond_eval
    import mips_branch_pkg::*;
(
    input  logic [2:0] br_kind,
    input  logic       lt,
    input  logic       gt,
    input  logic       eq,
    output logic       taken,
    output logic       flag_err
);

    logic one_hot;
    logic uses_flags;
    logic raw_taken;

    always_comb begin
        one_hot    = 1'b0;
        uses_flags = (br_kind != BR_NONE) && (br_kind != BR_JUMP);
        raw_taken  = 1'b0;

        case ({lt, gt, eq})
            3'b100, 3'b010, 3'b001: one_hot = 1'b1;
            default:                one_hot = 1'b0;
        endcase

        case (br_kind)
            BR_BEQ:  raw_taken = eq;
            BR_BNE:  raw_taken = !eq;
            BR_BLT:  raw_taken = lt;
            BR_BGT:  raw_taken = gt;
            BR_BLE:  raw_taken = lt | eq;
            BR_BGE:  raw_taken = gt | eq;
            BR_JUMP: raw_taken = 1'b1;
            default: raw_taken = 1'b0;
        endcase

        flag_err = uses_flags && !one_hot;
        taken    = raw_taken && !flag_err;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch resolve stage: condition, next-PC, valid/ready result register and statistics.
module branch_resolve_unit
    import mips_branch_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_resolve_unit_if.slave bus,
    input  logic             flush,
    input  logic             clr_stats,
    output logic             err_sticky,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] ntaken_cnt
);

    logic            c_taken;
    logic            c_flag_err;
    logic [PC_W-1:0] c_next_pc;
    logic            accept;
    logic            xfer;

    logic            out_valid_q;
    logic            taken_q;
    logic [PC_W-1:0] next_pc_q;
    logic            flag_err_q;

    branch_cond_eval u_cond (
        .br_kind  (bus.br_kind),
        .lt       (bus.lt),
        .gt       (bus.gt),
        .eq       (bus.eq),
        .taken    (c_taken),
        .flag_err (c_flag_err)
    );

    always_comb begin
        bus.in_ready = !flush && (!out_valid_q || bus.out_ready);
        accept       = bus.in_valid && bus.in_ready;
        xfer         = out_valid_q && bus.out_ready;
        c_next_pc    = c_taken ? (bus.pc + PC_W'(1) + bus.offset) : (bus.pc + PC_W'(1));
    end

    // accept already excludes flush, so a flush cycle can only drain, never load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            next_pc_q   <= '0;
            flag_err_q  <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            taken_q     <= c_taken;
            next_pc_q   <= c_next_pc;
            flag_err_q  <= c_flag_err;
        end else if (flush || xfer) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_stats) begin
            taken_cnt  <= '0;
            ntaken_cnt <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (xfer && taken_q && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
            if (xfer && !taken_q && (ntaken_cnt != '1)) begin
                ntaken_cnt <= ntaken_cnt + CNT_W'(1);
            end
            if (accept && c_flag_err) begin
                err_sticky <= 1'b1;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.taken     = taken_q;
    assign bus.next_pc   = next_pc_q;
    assign bus.flag_err  = flag_err_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        clr_stats;
    logic        err_sticky;
    logic [15:0] taken_cnt;
    logic [15:0] ntaken_cnt;

    int unsigned errors;
    int unsigned checks;

    branch_resolve_unit_if #(.PC_W(16)) bus ();

    branch_resolve_unit #(.PC_W(16), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .flush      (flush),
        .clr_stats  (clr_stats),
        .err_sticky (err_sticky),
        .taken_cnt  (taken_cnt),
        .ntaken_cnt (ntaken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one edge and land 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] kind, input logic [2:0] lge,
                         input logic [15:0] pc_v, input logic [15:0] off_v);
        bus.br_kind = kind;
        {bus.lt, bus.gt, bus.eq} = lge;
        bus.pc = pc_v;
        bus.offset = off_v;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        clr_stats = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        drive(3'b000, 3'b000, 16'h0, 16'h0);
        step();
        step();
        rst_n = 1'b1;

        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_taken", 32'(bus.taken), 0);
        chk("rst_next_pc", 32'(bus.next_pc), 0);
        chk("rst_flag_err", 32'(bus.flag_err), 0);
        chk("rst_sticky", 32'(err_sticky), 0);
        chk("rst_taken_cnt", 32'(taken_cnt), 0);
        chk("rst_ntaken_cnt", 32'(ntaken_cnt), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);

        // BEQ taken
        drive(3'b001, 3'b001, 16'h0010, 16'h0004);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("beq_valid", 32'(bus.out_valid), 1);
        chk("beq_taken", 32'(bus.taken), 1);
        chk("beq_next_pc", 32'(bus.next_pc), 'h0015);
        chk("beq_flag_err", 32'(bus.flag_err), 0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("beq_xfer_valid", 32'(bus.out_valid), 0);
        chk("beq_taken_cnt", 32'(taken_cnt), 1);
        chk("beq_ntaken_cnt", 32'(ntaken_cnt), 0);

        // BLT with gt set, not taken, pc wraps
        drive(3'b011, 3'b010, 16'hFFFF, 16'h0003);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("blt_taken", 32'(bus.taken), 0);
        chk("blt_next_pc_wrap", 32'(bus.next_pc), 'h0000);
        bus.out_ready = 1'b1;
        step();
        chk("blt_ntaken_cnt", 32'(ntaken_cnt), 1);
        chk("blt_xfer_valid", 32'(bus.out_valid), 0);

        // NONE with garbage flags: no error, not taken
        drive(3'b000, 3'b110, 16'h0005, 16'h0003);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        chk("none_taken", 32'(bus.taken), 0);
        chk("none_flag_err", 32'(bus.flag_err), 0);
        chk("none_next_pc", 32'(bus.next_pc), 'h0006);
        chk("none_sticky", 32'(err_sticky), 0);
        bus.out_ready = 1'b1;
        step();
        chk("none_ntaken_cnt", 32'(ntaken_cnt), 2);

        // BGE with lt and gt both set: malformed
        drive(3'b110, 3'b110, 16'h0020, 16'h0005);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        chk("bge_flag_err", 32'(bus.flag_err), 1);
        chk("bge_taken", 32'(bus.taken), 0);
        chk("bge_next_pc", 32'(bus.next_pc), 'h0021);
        chk("bge_sticky", 32'(err_sticky), 1);
        bus.out_ready = 1'b1;
        step();
        chk("bge_ntaken_cnt", 32'(ntaken_cnt), 3);
        chk("bge_taken_cnt", 32'(taken_cnt), 1);

        // JUMP ignores flags, negative offset; clear wins over the same-cycle transfer
        drive(3'b111, 3'b110, 16'h0100, 16'hFFFE);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        chk("jump_taken", 32'(bus.taken), 1);
        chk("jump_flag_err", 32'(bus.flag_err), 0);
        chk("jump_next_pc", 32'(bus.next_pc), 'h00FF);
        bus.out_ready = 1'b1;
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        bus.out_ready = 1'b0;
        chk("clr_taken_cnt", 32'(taken_cnt), 0);
        chk("clr_ntaken_cnt", 32'(ntaken_cnt), 0);
        chk("clr_sticky", 32'(err_sticky), 0);
        chk("clr_datapath_valid", 32'(bus.out_valid), 0);

        // Backpressure: A held while B waits
        drive(3'b010, 3'b100, 16'h0030, 16'h0010);
        bus.in_valid = 1'b1;
        step();
        drive(3'b010, 3'b001, 16'h0050, 16'h0007);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 32'(bus.in_ready), 0);
            chk("bp_valid", 32'(bus.out_valid), 1);
            chk("bp_taken", 32'(bus.taken), 1);
            chk("bp_next_pc", 32'(bus.next_pc), 'h0041);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(bus.in_ready), 1);
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("bp_b_valid", 32'(bus.out_valid), 1);
        chk("bp_b_taken", 32'(bus.taken), 0);
        chk("bp_b_next_pc", 32'(bus.next_pc), 'h0051);
        chk("bp_taken_cnt", 32'(taken_cnt), 1);

        // Flush while held and stalled, with a new record offered
        drive(3'b001, 3'b001, 16'h0060, 16'h0001);
        bus.in_valid = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(bus.in_ready), 0);
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_valid", 32'(bus.out_valid), 0);
        chk("flush_taken_cnt", 32'(taken_cnt), 1);
        chk("flush_ntaken_cnt", 32'(ntaken_cnt), 0);
        step();
        chk("flush_no_load", 32'(bus.out_valid), 0);

        // Transfer in the flush cycle still counts
        drive(3'b101, 3'b100, 16'h0000, 16'h7FFF);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("ble_next_pc", 32'(bus.next_pc), 'h8000);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.out_ready = 1'b0;
        chk("flush_xfer_valid", 32'(bus.out_valid), 0);
        chk("flush_xfer_cnt", 32'(taken_cnt), 2);

        // Saturation: 0xFFFF back-to-back JUMP transfers
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        drive(3'b111, 3'b000, 16'h1000, 16'h0000);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 32'h10000; i++) step();
        bus.in_valid = 1'b0;
        chk("sat_taken_cnt", 32'(taken_cnt), 'hFFFF);
        chk("sat_valid_held", 32'(bus.out_valid), 1);
        step();
        bus.out_ready = 1'b0;
        chk("sat_no_wrap", 32'(taken_cnt), 'hFFFF);
        chk("sat_ntaken_cnt", 32'(ntaken_cnt), 0);
        chk("sat_drained", 32'(bus.out_valid), 0);

        // Malformed (all-zero flags) record held, then reset mid-handshake
        drive(3'b001, 3'b000, 16'h0200, 16'h0004);
        bus.in_valid = 1'b1;
        step();
        chk("zero_flags_err", 32'(bus.flag_err), 1);
        chk("zero_flags_sticky", 32'(err_sticky), 1);
        chk("zero_flags_next_pc", 32'(bus.next_pc), 'h0201);
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("rst2_valid", 32'(bus.out_valid), 0);
        chk("rst2_taken", 32'(bus.taken), 0);
        chk("rst2_next_pc", 32'(bus.next_pc), 0);
        chk("rst2_flag_err", 32'(bus.flag_err), 0);
        chk("rst2_sticky", 32'(err_sticky), 0);
        chk("rst2_taken_cnt", 32'(taken_cnt), 0);
        chk("rst2_ntaken_cnt", 32'(ntaken_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
